iwb_select_stage: RTL and testbench

- Parametrised, registered successor to the combinational integer-writeback select.
- Picks one of four result sources (dmem, ALU, PC+increment, immediate) and registers it together with the destination register address and write enable.
- Uses a valid/ready handshake on both sides, and waits a variable number of cycles for load data.
- Sits between execute/memory and the register-file write port.
- Keeps a wrapping count of retired register writes.

---
 rtl/iwb_select_stage.sv | 118 +++++++++++
 tb/tb_iwb_select_stage.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/iwb_select_stage.sv
// Registered integer-writeback select: picks dmem/ALU/link/immediate result, holds it behind a
// valid/ready handshake, waits for late load data and counts retired register writes.
module iwb_select_stage #(
  parameter int XLEN     = 32,
  parameter int RADDR_W  = 5,
  parameter int PC_INC   = 4,
  parameter int RETIRE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          IWB_SEL,
  input  logic [XLEN-1:0]     alu_output,
  input  logic [XLEN-1:0]     dmem_output,
  input  logic                dmem_valid,
  input  logic [XLEN-1:0]     PC_output,
  input  logic [XLEN-1:0]     imm_output,
  input  logic [RADDR_W-1:0]  rd_addr,
  input  logic                rd_we,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     wb_data,
  output logic [RADDR_W-1:0]  wb_addr,
  output logic                wb_we,
  output logic [RETIRE_W-1:0] retired_count
);

  // state    | meaning
  // IDLE     | empty, ready for a bundle
  // WAIT_MEM | load accepted, waiting for dmem_valid
  // FULL     | result held, presented downstream
  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_MEM = 2'd1,
    S_FULL     = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [XLEN-1:0]       r_data;
  logic [RADDR_W-1:0]    r_addr;
  logic                  r_we;
  logic [RETIRE_W-1:0]   r_count;

  logic                  w_accept;
  logic                  w_load_now;
  logic                  w_mem_done;
  logic                  w_retire;
  logic [XLEN-1:0]       w_sel_data;

  assign out_valid = (r_state == S_FULL);
  assign in_ready  = (r_state == S_IDLE) || ((r_state == S_FULL) && out_ready);
  assign wb_data   = r_data;
  assign wb_addr   = r_addr;
  assign wb_we     = out_valid && r_we;
  assign retired_count = r_count;

  assign w_accept   = in_valid && in_ready;
  assign w_load_now = w_accept && ((IWB_SEL != 2'b00) || dmem_valid);
  assign w_mem_done = (r_state == S_WAIT_MEM) && dmem_valid;
  assign w_retire   = out_valid && out_ready && wb_we;

  always_comb begin
    w_sel_data = dmem_output;
    case (IWB_SEL)
      2'b01:   w_sel_data = alu_output;
      2'b10:   w_sel_data = PC_output + XLEN'(PC_INC);
      2'b11:   w_sel_data = imm_output;
      default: w_sel_data = dmem_output;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_next = w_load_now ? S_FULL : S_WAIT_MEM;
      end
      S_WAIT_MEM: begin
        if (dmem_valid) w_next = S_FULL;
      end
      S_FULL: begin
        if (out_ready) begin
          if (w_accept) w_next = w_load_now ? S_FULL : S_WAIT_MEM;
          else          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // addr/we are captured on every accept; data only once it is actually known
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_data <= '0;
      r_addr <= '0;
      r_we   <= 1'b0;
    end else if (w_accept) begin
      r_addr <= rd_addr;
      r_we   <= rd_we && (rd_addr != '0);
      if (w_load_now) r_data <= w_sel_data;
    end else if (w_mem_done) begin
      r_data <= dmem_output;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_count <= '0;
    else if (w_retire) r_count <= r_count + RETIRE_W'(1);
  end

endmodule

// File: tb/tb_iwb_select_stage.sv
// Randomized and directed check of iwb_select_stage against a slot-level reference model.
module tb_iwb_select_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [1:0]  IWB_SEL;
  logic [31:0] alu_output, dmem_output, PC_output, imm_output;
  logic        dmem_valid;
  logic [4:0]  rd_addr;
  logic        rd_we;
  logic        out_valid, out_ready;
  logic [31:0] wb_data;
  logic [4:0]  wb_addr;
  logic        wb_we;
  logic [1:0]  retired_count;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model: one optional result slot
  bit          m_busy, m_known, m_we;
  bit   [31:0] m_data;
  bit   [4:0]  m_addr;
  int          m_cnt;

  // last observed outputs
  logic        o_ready, o_valid, o_we;
  logic [31:0] o_data;
  logic [4:0]  o_addr;
  logic [1:0]  o_cnt;

  iwb_select_stage #(.XLEN(32), .RADDR_W(5), .PC_INC(4), .RETIRE_W(2)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .IWB_SEL(IWB_SEL),
    .alu_output(alu_output), .dmem_output(dmem_output), .dmem_valid(dmem_valid),
    .PC_output(PC_output), .imm_output(imm_output), .rd_addr(rd_addr), .rd_we(rd_we),
    .out_valid(out_valid), .out_ready(out_ready), .wb_data(wb_data), .wb_addr(wb_addr),
    .wb_we(wb_we), .retired_count(retired_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    m_busy = 0; m_known = 0; m_we = 0; m_data = 0; m_addr = 0; m_cnt = 0;
  endtask

  // one clock cycle: drive at negedge, check outputs, advance model for the coming posedge
  task automatic step(input bit iv, input bit [1:0] sel, input bit [31:0] alu,
                      input bit [31:0] dm, input bit dv, input bit [31:0] pc,
                      input bit [31:0] imm, input bit [4:0] rd, input bit we, input bit ordy);
    bit fire, acc;
    @(negedge clk);
    in_valid = iv; IWB_SEL = sel; alu_output = alu; dmem_output = dm; dmem_valid = dv;
    PC_output = pc; imm_output = imm; rd_addr = rd; rd_we = we; out_ready = ordy;
    #1;
    o_ready = in_ready; o_valid = out_valid; o_we = wb_we;
    o_data = wb_data; o_addr = wb_addr; o_cnt = retired_count;
    chk("in_ready", in_ready, m_busy ? (m_known && ordy) : 1'b1);
    chk("out_valid", out_valid, m_busy && m_known);
    chk("wb_we", wb_we, m_busy && m_known && m_we);
    chk("retired_count", retired_count, 64'(m_cnt));
    if (m_busy && m_known) begin
      chk("wb_data", wb_data, m_data);
      chk("wb_addr", wb_addr, m_addr);
    end
    fire = m_busy && m_known && ordy;
    acc  = iv && (!m_busy || fire);
    if (fire && m_we) m_cnt = (m_cnt + 1) % 4;
    if (m_busy && !m_known) begin
      if (dv) begin m_known = 1; m_data = dm; end
    end else if (acc) begin
      m_busy  = 1;
      m_addr  = rd;
      m_we    = we && (rd != 0);
      m_known = (sel != 0) || dv;
      if (m_known) m_data = (sel == 1) ? alu : (sel == 2) ? pc + 32'd4 : (sel == 3) ? imm : dm;
    end else if (fire) begin
      m_busy = 0;
    end
  endtask

  task automatic idle_step(input bit ordy);
    step(0, 2'b01, 0, 0, 0, 0, 0, 0, 0, ordy);
  endtask

  // asynchronous reset between edges; outputs must clear without a clock
  task automatic async_reset(input string tag);
    @(negedge clk);
    #2 reset = 1;
    in_valid = 0; dmem_valid = 0;
    #1;
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_wb_we"}, wb_we, 0);
    chk({tag, "_retired"}, retired_count, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    model_clear();
    @(negedge clk);
    reset = 0;
  endtask

  initial begin
    reset = 1; in_valid = 0; IWB_SEL = 0; alu_output = 0; dmem_output = 0; dmem_valid = 0;
    PC_output = 0; imm_output = 0; rd_addr = 0; rd_we = 0; out_ready = 0;
    model_clear();
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_wb_we", wb_we, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_addr", wb_addr, 0);
    chk("rst_retired", retired_count, 0);
    @(negedge clk); @(negedge clk);
    reset = 0;

    // ALU path
    step(1, 2'b01, 32'h0000_1234, 0, 0, 0, 0, 5, 1, 1);
    idle_step(1);
    chk("alu_valid", o_valid, 1);
    chk("alu_data", o_data, 32'h0000_1234);
    chk("alu_addr", o_addr, 5);
    chk("alu_we", o_we, 1);
    chk("alu_cnt0", o_cnt, 0);
    idle_step(1);
    chk("alu_cnt1", o_cnt, 1);

    // link wrap
    step(1, 2'b10, 0, 0, 0, 32'hFFFF_FFFC, 0, 1, 1, 1);
    idle_step(1);
    chk("link_wrap", o_data, 32'h0);

    // load waits three cycles
    step(1, 2'b00, 0, 32'h1111_1111, 0, 0, 0, 7, 1, 1);
    for (int i = 0; i < 3; i++) begin
      step(1, 2'b01, 32'h55, 0, 0, 0, 0, 9, 1, 1);
      chk("wait_in_ready", o_ready, 0);
    end
    step(0, 2'b01, 0, 32'hDEAD_BEEF, 1, 0, 0, 0, 0, 1);
    chk("wait_no_valid", o_valid, 0);
    idle_step(1);
    chk("load_valid", o_valid, 1);
    chk("load_data", o_data, 32'hDEAD_BEEF);

    // load with data on accept cycle
    step(1, 2'b00, 0, 32'hCAFE_F00D, 1, 0, 0, 8, 1, 1);
    idle_step(1);
    chk("fast_load", o_data, 32'hCAFE_F00D);
    idle_step(1);

    // backpressure
    step(1, 2'b01, 32'hAAAA, 0, 0, 0, 0, 3, 1, 1);
    for (int i = 0; i < 4; i++) begin
      step(1, 2'b11, 0, 0, 0, 0, 32'hBBBB, 4, 1, 0);
      chk("bp_data", o_data, 32'hAAAA);
      chk("bp_in_ready", o_ready, 0);
    end
    step(1, 2'b11, 0, 0, 0, 0, 32'hBBBB, 4, 1, 1);
    chk("bp_ready", o_ready, 1);
    idle_step(1);
    chk("b2b_valid", o_valid, 1);
    chk("b2b_data", o_data, 32'hBBBB);

    // x0 suppression
    step(1, 2'b01, 32'h77, 0, 0, 0, 0, 0, 1, 1);
    idle_step(1);
    chk("x0_valid", o_valid, 1);
    chk("x0_we", o_we, 0);
    idle_step(1);

    // reset in WAIT_MEM, later dmem_valid ignored
    step(1, 2'b00, 0, 0, 0, 0, 0, 6, 1, 1);
    async_reset("rst_wait");
    step(0, 2'b00, 0, 32'h1234_5678, 1, 0, 0, 0, 0, 1);
    idle_step(1);
    chk("rst_wait_no_out", o_valid, 0);

    // reset in FULL under backpressure
    step(1, 2'b01, 32'h99, 0, 0, 0, 0, 2, 1, 0);
    idle_step(0);
    chk("full_before_rst", o_valid, 1);
    async_reset("rst_full");

    // counter wraps at 2 bits
    for (int i = 0; i < 5; i++) step(1, 2'b01, 32'(i), 0, 0, 0, 0, 5'(i + 1), 1, 1);
    idle_step(1);
    idle_step(1);
    chk("cnt_wrap", o_cnt, 1);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 9) < 7, 2'($urandom), $urandom, $urandom, $urandom_range(0, 9) < 3,
           $urandom_range(0, 3) == 0 ? 32'hFFFF_FFFC : $urandom, $urandom,
           $urandom_range(0, 4) == 0 ? 5'd0 : 5'($urandom), 1'($urandom), $urandom_range(0, 9) < 7);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
